// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry
//   Turns debounced keypad codes into two BCD operands. Digits 0-9 shift into
//   the operand being entered (most-significant digit ends up in the upper
//   nibble). A ends operand A, B ends operand B, C clears everything, E/F are
//   ignored. Completing B raises ops_valid for exactly one cycle.
//
//   Optional feature: define KEYPAD_BACKSPACE_EN to make key D delete the last
//   digit of the operand being entered (S_A / S_B only). Without the macro, D
//   is ignored and no backspace logic exists.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   key_code   hex key code from scanner
//   key_valid  debounced key-pressed level; accepted on its rising edge
//   op_a/op_b  BCD operands, width 4*N_DIGITS
//   entry_val  operand currently being entered (shows op_b once done)
//   phase      00=S_A, 01=S_B, 10=S_DONE
//   ops_valid  one-cycle pulse when both operands are complete
//   digit_cnt  digits held in the current operand (saturates at N_DIGITS)
//
// N_DIGITS must be >= 2.
module keypad_operand_entry #(
  parameter int N_DIGITS = 3,
  localparam int W  = 4 * N_DIGITS,
  localparam int CW = ($clog2(N_DIGITS + 1) < 2) ? 2 : $clog2(N_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    key_code,
  input  logic          key_valid,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic [W-1:0]  entry_val,
  output logic [1:0]    phase,
  output logic          ops_valid,
  output logic [CW-1:0] digit_cnt
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  op_a_d, op_b_d, entry_d;
  logic [CW-1:0] cnt_d;
  logic          ops_valid_d;

  logic          prev_valid;
  logic          accept;
  logic          full;
  logic [W-1:0]  shifted;
  logic [W-1:0]  first_digit;

  // prev_valid follows key_valid even while reset is held: a key that was
  // down during reset is thereby discarded instead of being accepted on the
  // first cycle after reset releases.
  always_ff @(posedge clk) begin
    prev_valid <= key_valid;
  end

  assign accept      = key_valid & ~prev_valid;
  assign full        = (digit_cnt == CW'(N_DIGITS));
  assign shifted     = {entry_val[W-5:0], key_code};
  assign first_digit = {{(W-4){1'b0}}, key_code};
  assign phase       = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_A;
      op_a      <= '0;
      op_b      <= '0;
      entry_val <= '0;
      digit_cnt <= '0;
      ops_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
      entry_val <= entry_d;
      digit_cnt <= cnt_d;
      ops_valid <= ops_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a;
    op_b_d      = op_b;
    entry_d     = entry_val;
    cnt_d       = digit_cnt;
    ops_valid_d = 1'b0;

    if (accept) begin
      if (key_code <= 4'd9) begin
        case (state_q)
          S_A: if (!full) begin
            entry_d = shifted;
            op_a_d  = shifted;
            cnt_d   = digit_cnt + CW'(1);
          end
          S_B: if (!full) begin
            entry_d = shifted;
            op_b_d  = shifted;
            cnt_d   = digit_cnt + CW'(1);
          end
          S_DONE: begin
            // A digit after completion starts a fresh calculation.
            entry_d = first_digit;
            op_a_d  = first_digit;
            op_b_d  = '0;
            cnt_d   = CW'(1);
            state_d = S_A;
          end
          default: ;
        endcase
      end else begin
        case (key_code)
          4'hA: if (state_q == S_A) begin
            state_d = S_B;
            entry_d = '0;
            cnt_d   = '0;
          end
          4'hB: if (state_q == S_B) begin
            state_d     = S_DONE;
            ops_valid_d = 1'b1;
          end
          4'hC: begin
            state_d = S_A;
            op_a_d  = '0;
            op_b_d  = '0;
            entry_d = '0;
            cnt_d   = '0;
          end
`ifdef KEYPAD_BACKSPACE_EN
          4'hD: if (state_q != S_DONE && digit_cnt != '0) begin
            entry_d = {4'h0, entry_val[W-1:4]};
            if (state_q == S_A) op_a_d = {4'h0, entry_val[W-1:4]};
            else                op_b_d = {4'h0, entry_val[W-1:4]};
            cnt_d = digit_cnt - CW'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry (N_DIGITS=3): vector table, hand-written
// multi-cycle sequences, then random keys against a digit-queue model.
module tb_keypad_operand_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [11:0] op_a, op_b, entry_val;
  logic [1:0]  phase;
  logic        ops_valid;
  logic [1:0]  digit_cnt;

  int checks   = 0;
  int failures = 0;

  keypad_operand_entry #(.N_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .op_a(op_a), .op_b(op_b), .entry_val(entry_val), .phase(phase),
    .ops_valid(ops_valid), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [11:0] a, b, e;
    logic [1:0]  ph;
    logic [1:0]  cnt;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  // Reference model: operands kept as lists of decimal digits.
  int   ph_m;
  int   da[$];
  int   db[$];
  logic ov_m;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] e, input logic [1:0] ph, input logic [1:0] cnt,
                         input logic ov);
    chk({tag, ".op_a"}, op_a, a);
    chk({tag, ".op_b"}, op_b, b);
    chk({tag, ".entry_val"}, entry_val, e);
    chk({tag, ".phase"}, phase, ph);
    chk({tag, ".digit_cnt"}, digit_cnt, cnt);
    chk({tag, ".ops_valid"}, ops_valid, ov);
  endtask

  // Raise key_valid for 'hold' cycles; returns at the negedge where
  // key_valid drops, i.e. the first sample point after the accept edge
  // when hold==1.
  task automatic press(input logic [3:0] c, input int hold);
    @(negedge clk);
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
  endtask

  function automatic void add(input logic [3:0] c, input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] e, input logic [1:0] ph, input logic [1:0] cnt,
                              input logic ov);
    tbl.push_back('{code: c, a: a, b: b, e: e, ph: ph, cnt: cnt, ov: ov});
  endfunction

  function automatic logic [11:0] pack(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v[11:0];
  endfunction

  function automatic void model_key(input int c);
    ov_m = 1'b0;
    if (c == 12) begin
      da.delete(); db.delete(); ph_m = 0;
    end else if (c <= 9) begin
      if (ph_m == 2) begin
        da.delete(); db.delete(); da.push_back(c); ph_m = 0;
      end else if (ph_m == 0) begin
        if (da.size() < 3) da.push_back(c);
      end else begin
        if (db.size() < 3) db.push_back(c);
      end
    end else if (c == 10 && ph_m == 0) begin
      ph_m = 1;
    end else if (c == 11 && ph_m == 1) begin
      ph_m = 2; ov_m = 1'b1;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (c == 13 && ph_m == 0 && da.size() > 0) void'(da.pop_back());
    else if (c == 13 && ph_m == 1 && db.size() > 0) void'(db.pop_back());
`endif
  endfunction

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;

    // Vector table: {key, op_a, op_b, entry_val, phase, digit_cnt, ops_valid}
    add(4'h1, 12'h001, 12'h000, 12'h001, 2'b00, 2'd1, 1'b0);
    add(4'h2, 12'h012, 12'h000, 12'h012, 2'b00, 2'd2, 1'b0);
    add(4'hA, 12'h012, 12'h000, 12'h000, 2'b01, 2'd0, 1'b0);
    add(4'h4, 12'h012, 12'h004, 12'h004, 2'b01, 2'd1, 1'b0);
    add(4'h5, 12'h012, 12'h045, 12'h045, 2'b01, 2'd2, 1'b0);
    add(4'hB, 12'h012, 12'h045, 12'h045, 2'b10, 2'd2, 1'b1);
    add(4'hA, 12'h012, 12'h045, 12'h045, 2'b10, 2'd2, 1'b0);
    add(4'hB, 12'h012, 12'h045, 12'h045, 2'b10, 2'd2, 1'b0);
    add(4'hE, 12'h012, 12'h045, 12'h045, 2'b10, 2'd2, 1'b0);
    add(4'hD, 12'h012, 12'h045, 12'h045, 2'b10, 2'd2, 1'b0);
    add(4'h5, 12'h005, 12'h000, 12'h005, 2'b00, 2'd1, 1'b0);
    add(4'hC, 12'h000, 12'h000, 12'h000, 2'b00, 2'd0, 1'b0);
    add(4'h9, 12'h009, 12'h000, 12'h009, 2'b00, 2'd1, 1'b0);
    add(4'h8, 12'h098, 12'h000, 12'h098, 2'b00, 2'd2, 1'b0);
    add(4'h7, 12'h987, 12'h000, 12'h987, 2'b00, 2'd3, 1'b0);
    add(4'h6, 12'h987, 12'h000, 12'h987, 2'b00, 2'd3, 1'b0);
    add(4'hB, 12'h987, 12'h000, 12'h987, 2'b00, 2'd3, 1'b0);
    add(4'hF, 12'h987, 12'h000, 12'h987, 2'b00, 2'd3, 1'b0);
    add(4'hA, 12'h987, 12'h000, 12'h000, 2'b01, 2'd0, 1'b0);
    add(4'hA, 12'h987, 12'h000, 12'h000, 2'b01, 2'd0, 1'b0);
    add(4'h6, 12'h987, 12'h006, 12'h006, 2'b01, 2'd1, 1'b0);
    add(4'hC, 12'h000, 12'h000, 12'h000, 2'b00, 2'd0, 1'b0);
    add(4'h3, 12'h003, 12'h000, 12'h003, 2'b00, 2'd1, 1'b0);
    add(4'hA, 12'h003, 12'h000, 12'h000, 2'b01, 2'd0, 1'b0);
    add(4'hC, 12'h000, 12'h000, 12'h000, 2'b00, 2'd0, 1'b0);
    add(4'hA, 12'h000, 12'h000, 12'h000, 2'b01, 2'd0, 1'b0);
    add(4'hB, 12'h000, 12'h000, 12'h000, 2'b10, 2'd0, 1'b1);
    add(4'hC, 12'h000, 12'h000, 12'h000, 2'b00, 2'd0, 1'b0);
    add(4'hD, 12'h000, 12'h000, 12'h000, 2'b00, 2'd0, 1'b0);
    add(4'h1, 12'h001, 12'h000, 12'h001, 2'b00, 2'd1, 1'b0);
    add(4'h2, 12'h012, 12'h000, 12'h012, 2'b00, 2'd2, 1'b0);
`ifdef KEYPAD_BACKSPACE_EN
    add(4'hD, 12'h001, 12'h000, 12'h001, 2'b00, 2'd1, 1'b0);
    add(4'h3, 12'h013, 12'h000, 12'h013, 2'b00, 2'd2, 1'b0);
`else
    add(4'hD, 12'h012, 12'h000, 12'h012, 2'b00, 2'd2, 1'b0);
    add(4'h3, 12'h123, 12'h000, 12'h123, 2'b00, 2'd3, 1'b0);
`endif

    // Reset state after two reset edges.
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 12'h0, 12'h0, 12'h0, 2'b00, 2'd0, 1'b0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      press(tbl[i].code, 1);
      chk_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].e,
              tbl[i].ph, tbl[i].cnt, tbl[i].ov);
      @(negedge clk);
      chk($sformatf("vec%0d.pulse_end", i), ops_valid, 1'b0);
    end

    // Reset coinciding with a key accept: key discarded, even while held.
    @(negedge clk);
    key_code = 4'h5; key_valid = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk_all("rst_key", 12'h0, 12'h0, 12'h0, 2'b00, 2'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("rst_key_held", 12'h0, 12'h0, 12'h0, 2'b00, 2'd0, 1'b0);
    key_valid = 1'b0;

    // A key held for 50 cycles is accepted once.
    press(4'h7, 50);
    chk_all("hold7", 12'h007, 12'h0, 12'h007, 2'b00, 2'd1, 1'b0);

    // Random keys against the model.
    press(4'hC, 1);
    da.delete(); db.delete(); ph_m = 0; ov_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int c;
      c = $urandom_range(0, 15);
      press(c[3:0], 1);
      model_key(c);
      chk_all($sformatf("rnd%0d", n), pack(da), pack(db),
              (ph_m == 0) ? pack(da) : pack(db), ph_m[1:0],
              (ph_m == 0) ? da.size() : db.size(), ov_m);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk($sformatf("rnd%0d.pulse_end", n), ops_valid, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
- Sits directly downstream of the keypad scanner/debouncer. Consumes its 4-bit hex key code and key-valid level.
- Assembles two multi-digit BCD operands through a small entry state machine, then presents both operands with a one-cycle valid strobe.
- Feeds the arithmetic/display stages.
- Keys 0x0–0x9 are digits; 0xA ends operand A, 0xB ends operand B, 0xC clears; 0xE/0xF are ignored. 0xD is ignored unless the optional feature is enabled.

Parameters:
- N_DIGITS, 3, maximum BCD digits per operand; operand width = 4*N_DIGITS.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (reset when rst==0 at a rising clk edge)
- key_code  input  4  hex code of pressed key from scanner
- key_valid  input  1  debounced key-pressed level from scanner
- op_a  output  4*N_DIGITS  operand A, BCD, most-significant digit in the upper nibble
- op_b  output  4*N_DIGITS  operand B, BCD
- entry_val  output  4*N_DIGITS  operand currently being entered, for display
- phase  output  2  00=S_A, 01=S_B, 10=S_DONE
- ops_valid  output  1  one-cycle pulse when both operands are complete
- digit_cnt  output  2..clog2(N_DIGITS+1)  digits held in the current operand

Behaviour:
- Reset (rst==0 at edge): state S_A; op_a, op_b, entry_val, digit_cnt = 0; ops_valid = 0. Reset overrides any key event in the same cycle.
- Key accept:
  - Previous key_valid is registered; a key is accepted only in a cycle where key_valid==1 and prev==0.
  - key_code is sampled in that same cycle.
  - A held key yields exactly one accept. key_valid low→high→low→high yields two accepts.
- Latency: every accepted key updates registers at that edge; results are visible the next cycle. No other latency.
- Digit shift rule: entry_val <= {entry_val[4*N_DIGITS-5:0], key_code}; digit_cnt++.
- Digit accepted when digit_cnt==N_DIGITS: dropped, no register changes (saturating entry, no wrap).
- S_A:
  - digit → shift into entry_val and op_a, which mirror each other.
  - 0xA → state S_B; entry_val and digit_cnt cleared; op_a holds. Zero digits entered is legal (op_a = 0).
  - 0xB → ignored.
- S_B:
  - digit → shift into entry_val and op_b, which mirror each other.
  - 0xB → state S_DONE; ops_valid = 1 for exactly the next cycle.
  - 0xA → ignored.
- S_DONE:
  - op_a and op_b hold; entry_val shows op_b.
  - digit → op_a, op_b, entry_val cleared; that digit becomes the first digit of the new op_a; state S_A; digit_cnt = 1.
  - 0xA and 0xB → ignored.
- 0xC in any state: clear op_a, op_b, entry_val, digit_cnt; state S_A; ops_valid = 0.
- 0xE, 0xF: ignored in all states. 0xD: ignored in all states when the optional feature is disabled.
- ops_valid is never asserted for more than one consecutive cycle.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: key 0xD in S_A or S_B deletes the last digit.
  - entry_val <= {4'h0, entry_val[4*N_DIGITS-1:4]}, and the active operand is updated the same way.
  - digit_cnt--.
  - With digit_cnt==0, or in S_DONE, 0xD is a no-op.
- Undefined: 0xD is ignored in every state; no backspace logic is synthesized.

Test Plan:
- Reset with rst=0 for 2 cycles, then key_valid pulses 1,2,A,4,5,B → op_a=12'h012, op_b=12'h045, ops_valid high exactly 1 cycle after the B accept, phase=10.
- Hold key_valid=1 with code 7 for 50 cycles in S_A → op_a=12'h007, digit_cnt=1 (single accept).
- Enter digits 9,8,7,6 in S_A → op_a=12'h987, 4th digit dropped, digit_cnt=3.
- Keys 3,A,C → op_a=0, op_b=0, phase=00, ops_valid never asserted; then A,B → op_a=0, op_b=0, ops_valid pulses.
- In S_DONE press 5 → op_a=12'h005, op_b=0, phase=00; assert rst=0 in the same cycle as a key accept → all outputs 0 and the key is discarded.
- KEYPAD_BACKSPACE_EN defined: keys 1,2,D,3 → op_a=12'h013. Undefined: keys 1,2,D,3 → op_a=12'h123.
